iob2axi_rd_burst: RTL and testbench
===================================

// Module: iob2axi_rd_burst
// PURPOSE
//  Native-to-AXI4 read master for transfers of any length. One control command (addr, word count)
//  is split into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary.
//  Read data is streamed to the native slave port. Sits between DMA/accelerator cores and the AXI interconnect.
// PARAMETERS
//  ADDR_W     32  byte address width (AXI and control)
//  DATA_W     32  data width; power of 2, >=8
//  CNT_W      16  transfer length width (words)
//  MAX_BURST  16  max beats per burst; power of 2, 1..256
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous reset, active-high
//  run            in   1          start command; sampled only while ready=1
//  addr           in   ADDR_W     start byte address, DATA_W/8-aligned
//  length         in   CNT_W      word count minus 1
//  ready          out  1          idle, command accepted when run=1
//  error          out  1          sticky error of last transfer; cleared on next accepted run
//  s_valid        in   1          native sink can take a word
//  s_rdata        out  DATA_W     read word (registered)
//  s_ready        out  1          s_rdata valid this cycle (registered)
//  m_axi_arid     out  AXI_ID_W   constant 0
//  m_axi_araddr   out  ADDR_W     burst address
//  m_axi_arlen    out  8          burst beats minus 1
//  m_axi_arsize   out  3          constant $clog2(DATA_W/8)
//  m_axi_arburst  out  2          constant 1 (INCR)
//  m_axi_arlock   out  1 ; m_axi_arcache out 4 (=2) ; m_axi_arprot out 3 (=2) ; m_axi_arqos out 4 (=0)
//  m_axi_arvalid  out  1  ; m_axi_arready in 1
//  m_axi_rid in AXI_ID_W (ignored) ; m_axi_rdata in DATA_W ; m_axi_rresp in 2 ; m_axi_rlast in 1
//  m_axi_rvalid   in   1  ; m_axi_rready out 1
// BEHAVIOUR
//  Reset: state IDLE, ready=1, error=0, arvalid=0, rready=0, s_ready=0, s_rdata=0, araddr=0, arlen=0.
//   Reset mid-transfer aborts at once; outstanding beats are dropped.
//  FSM states: IDLE, ADDR, DATA.
//  IDLE: ready=1. On run, latch addr as cur_addr, set remaining=length+1, clear error, go to ADDR.
//   ready falls the next cycle. run while busy is ignored.
//  ADDR: arvalid=1.
//   arlen = min(remaining, MAX_BURST, beats_to_4k)-1, where beats_to_4k = (4096-cur_addr[11:0])>>$clog2(DATA_W/8).
//   araddr and arlen are registered on entry and stay stable until arready.
//   On arvalid&arready: beat_cnt=arlen, go to DATA. No second AR is outstanding.
//  DATA: rready = s_valid (combinational). Beat = rvalid&rready.
//   Per beat: s_rdata<=rdata, s_ready<=1 (1-cycle latency); remaining-=1; cur_addr+=DATA_W/8; beat_cnt-=1.
//   rresp!=0 on any beat -> error<=1.
//   rlast must be 1 exactly on the beat with beat_cnt==0. A mismatch either way -> error<=1.
//   Burst length is governed by beat_cnt, not rlast.
//   After the final beat of a burst: remaining==0 -> IDLE (ready=1 next cycle), else -> ADDR.
//  Arithmetic: remaining is CNT_W+1 bits (length all-ones does not wrap).
//   cur_addr wraps modulo 2^ADDR_W. beats_to_4k is computed at 13 bits.
//  Simultaneous: an AR handshake and the final beat are never in the same cycle (single outstanding burst).
//   run in the cycle ready rises is accepted.
// TESTING
//  1 DATA_W=32, addr=0x100, length=3, s_valid=1 -> one AR: araddr=0x100, arlen=3; 4 s_ready pulses with data.
//    ready=1 afterwards, error=0.
//  2 addr=0x0, length=39 -> ARs arlen 15,15,7 at 0x000,0x040,0x080; 40 words delivered in order.
//  3 addr=0xFF8, length=7 -> AR arlen=1 @0xFF8, then arlen=5 @0x1000 (4 KB split).
//  4 rresp=2 on beat 2 of length=3 -> all 4 beats consumed, error=1 at completion; next run clears error to 0.
//  5 rlast low on final beat -> error=1. rlast high on beat 0 of a 4-beat burst -> error=1, remaining 3 beats still taken.
//  6 arready delayed 5 cycles, s_valid toggling -> arvalid/araddr/arlen stable, rready==s_valid, no beat lost.
//    rst asserted mid-DATA -> ready=1, arvalid=0, rready=0 immediately.

Source files
------------

// File: rtl/iob2axi_rd_burst_if.sv
// AXI4 read-address and read-data channels between the burst read master and the interconnect.
interface iob2axi_rd_burst_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned AXI_ID_W = 1
);
  logic [AXI_ID_W-1:0] arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [AXI_ID_W-1:0] rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/iob2axi_rd_burst.sv
// Native-to-AXI4 read master: splits one (addr, length) command into INCR bursts of at most
// MAX_BURST beats that never cross a 4 KB boundary, streaming read words to the native sink.
module iob2axi_rd_burst #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned AXI_ID_W  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [CNT_W-1:0]     length,
  output logic                 ready,
  output logic                 error,
  input  logic                 s_valid,
  output logic [DATA_W-1:0]    s_rdata,
  output logic                 s_ready,
  iob2axi_rd_burst_if.master   m_axi
);

  localparam int unsigned BytesPerBeat = DATA_W / 8;
  localparam int unsigned SizeLg       = $clog2(BytesPerBeat);
  localparam int unsigned LenW         = (CNT_W + 1 > 13) ? CNT_W + 1 : 13;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [CNT_W:0]      remaining_q, remaining_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [7:0]          arlen_q, arlen_d;
  logic                arvalid_q, arvalid_d;
  logic                error_q, error_d;
  logic                s_ready_q, s_ready_d;
  logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;

  logic                rready;
  logic                beat;
  logic                load_ar;
  logic [12:0]         beats_to_4k;
  logic [LenW-1:0]     burst_len;
  logic [LenW-1:0]     burst_len_m1;

  assign rready = s_valid & (state_q == StData);
  assign beat   = m_axi.rvalid & rready;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    beat_cnt_d   = beat_cnt_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    error_d      = error_q;
    s_rdata_d    = s_rdata_q;
    s_ready_d    = 1'b0;
    load_ar      = 1'b0;
    beats_to_4k  = '0;
    burst_len    = '0;
    burst_len_m1 = '0;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          cur_addr_d  = addr;
          remaining_d = {1'b0, length} + (CNT_W + 1)'(1);
          error_d     = 1'b0;
          state_d     = StAddr;
          load_ar     = 1'b1;
        end
      end
      StAddr: begin
        if (m_axi.arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = arlen_q;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat) begin
          s_rdata_d   = m_axi.rdata;
          s_ready_d   = 1'b1;
          remaining_d = remaining_q - (CNT_W + 1)'(1);
          cur_addr_d  = cur_addr_q + ADDR_W'(BytesPerBeat);
          beat_cnt_d  = beat_cnt_q - 8'd1;
          // rlast is only cross-checked; beat_cnt alone ends the burst
          if ((m_axi.rresp != 2'b00) || (m_axi.rlast != (beat_cnt_q == 8'd0))) begin
            error_d = 1'b1;
          end
          if (beat_cnt_q == 8'd0) begin
            if (remaining_d == '0) begin
              state_d = StIdle;
            end else begin
              state_d = StAddr;
              load_ar = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Next burst is sized from the address/count it will start at
    beats_to_4k = (13'd4096 - {1'b0, cur_addr_d[11:0]}) >> SizeLg;
    burst_len   = LenW'(remaining_d);
    if (burst_len > LenW'(MAX_BURST)) burst_len = LenW'(MAX_BURST);
    if (burst_len > LenW'(beats_to_4k)) burst_len = LenW'(beats_to_4k);
    burst_len_m1 = burst_len - LenW'(1);

    if (load_ar) begin
      arvalid_d = 1'b1;
      araddr_d  = cur_addr_d;
      arlen_d   = burst_len_m1[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      error_q     <= 1'b0;
      s_rdata_q   <= '0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      error_q     <= error_d;
      s_rdata_q   <= s_rdata_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign ready   = (state_q == StIdle);
  assign error   = error_q;
  assign s_rdata = s_rdata_q;
  assign s_ready = s_ready_q;

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = 3'(SizeLg);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd2;
  assign m_axi.arprot  = 3'd2;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready;

endmodule

// File: tb/tb_iob2axi_rd_burst.sv
// Bench for iob2axi_rd_burst: an AXI read slave and native sink driven cycle by cycle, checked
// against a burst-split and data model derived from the address/length arithmetic.
module tb_iob2axi_rd_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] addr;
  logic [15:0] length;
  logic        ready;
  logic        error;
  logic        s_valid;
  logic [31:0] s_rdata;
  logic        s_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] salt  = 32'h0;

  iob2axi_rd_burst_if #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(1)) axi ();

  iob2axi_rd_burst #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .MAX_BURST(16), .AXI_ID_W(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .addr    (addr),
    .length  (length),
    .ready   (ready),
    .error   (error),
    .s_valid (s_valid),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .m_axi   (axi)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ salt ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One command end to end; returns at a negedge with the bus quiet (or mid-transfer on abort).
  task automatic run_xfer(input logic [31:0] a0, input logic [15:0] len, input int ar_dly,
                          input bit rand_sv, input bit rand_rv, input int err_beat,
                          input int last_mode, input int abort_at);
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_len[$];
    logic [31:0] exp_data[$];
    logic [31:0] a, cur_baddr, seen_addr;
    logic [7:0]  seen_len;
    int          rem, n, b4k, cur_beats, idx, ar_wait, gbeat, burst_no, cycles;
    bit          phase, ar_seen, ar_fire, r_fire, rv, first, exp_err;

    salt = $urandom;
    a    = a0;
    rem  = int'(len) + 1;
    while (rem > 0) begin
      b4k = (4096 - int'(a[11:0])) / 4;
      n   = rem;
      if (n > 16) n = 16;
      if (n > b4k) n = b4k;
      exp_addr.push_back(a);
      exp_len.push_back(8'(n - 1));
      a   += 32'(4 * n);
      rem -= n;
    end
    for (int i = 0; i <= int'(len); i++) exp_data.push_back(mem_word(a0 + 32'(4 * i)));
    exp_err = (err_beat >= 0 && err_beat <= int'(len)) || (last_mode != 0);

    chk("ready_before_run", 32'(ready), 1);
    run    = 1'b1;
    addr   = a0;
    length = len;
    first  = 1'b1;
    phase = 1'b0; ar_seen = 1'b0; ar_fire = 1'b0; r_fire = 1'b0; rv = 1'b0;
    idx = 0; ar_wait = 0; gbeat = 0; burst_no = 0; cycles = 0; cur_beats = 0;
    cur_baddr = '0; seen_addr = '0; seen_len = '0;

    while (1) begin
      @(negedge clk);
      if (first) begin
        run   = 1'b0;
        first = 1'b0;
        chk("ready_falls", 32'(ready), 0);
        chk("error_cleared", 32'(error), 0);
      end
      if (r_fire) begin
        chk("s_ready_pulse", 32'(s_ready), 1);
        if (exp_data.size() > 0) chk("s_rdata", s_rdata, exp_data.pop_front());
        gbeat++;
        idx++;
        rv = 1'b0;
        if (idx == cur_beats) begin
          phase = 1'b0;
          burst_no++;
        end
      end else begin
        chk("s_ready_idle", 32'(s_ready), 0);
      end
      if (ar_fire) begin
        phase        = 1'b1;
        idx          = 0;
        ar_seen      = 1'b0;
        ar_wait      = 0;
        axi.arready  = 1'b0;
      end
      if (abort_at >= 0 && gbeat == abort_at) return;

      if (!phase && !ar_seen && exp_addr.size() == 0 && exp_data.size() == 0 && ready === 1'b1)
      begin
        chk("error_final", 32'(error), 32'(exp_err));
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.arready = 1'b0;
        return;
      end

      if (!phase) begin
        if (axi.arvalid === 1'b1) begin
          if (!ar_seen) begin
            if (exp_addr.size() == 0) begin
              chk("extra_ar", 32'(axi.arvalid), 0);
            end else begin
              cur_baddr = exp_addr.pop_front();
              cur_beats = int'(exp_len[0]) + 1;
              chk("araddr", axi.araddr, cur_baddr);
              chk("arlen", 32'(axi.arlen), 32'(exp_len.pop_front()));
            end
            ar_seen   = 1'b1;
            seen_addr = axi.araddr;
            seen_len  = axi.arlen;
          end else begin
            chk("araddr_stable", axi.araddr, seen_addr);
            chk("arlen_stable", 32'(axi.arlen), 32'(seen_len));
          end
          axi.arready = (ar_wait >= ar_dly);
          ar_wait++;
        end else if (ar_seen) begin
          chk("arvalid_held", 32'(axi.arvalid), 1);
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'd0;
      end else begin
        chk("arvalid_busy", 32'(axi.arvalid), 0);
        if (!rv) rv = rand_rv ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.rvalid = rv;
        axi.rdata  = mem_word(cur_baddr + 32'(4 * idx));
        axi.rresp  = (gbeat == err_beat) ? 2'd2 : 2'd0;
        axi.rlast  = (idx == cur_beats - 1);
        if (burst_no == 0 && last_mode == 1 && idx == cur_beats - 1) axi.rlast = 1'b0;
        if (burst_no == 0 && last_mode == 2 && idx == 0) axi.rlast = 1'b1;
      end
      s_valid = rand_sv ? 1'($urandom_range(0, 1)) : 1'b1;

      #1;
      chk("rready_follows", 32'(axi.rready), phase ? 32'(s_valid) : 0);
      ar_fire = (axi.arvalid === 1'b1) && axi.arready;
      r_fire  = axi.rvalid && (axi.rready === 1'b1);

      cycles++;
      if (cycles > 3000) begin
        chk("xfer_timeout", 32'(cycles), 3000);
        axi.rvalid  = 1'b0;
        axi.arready = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; addr = '0; length = '0; s_valid = 1'b0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
    axi.rlast = 1'b0; axi.rvalid = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_error", 32'(error), 0);
    chk("rst_arvalid", 32'(axi.arvalid), 0);
    chk("rst_rready", 32'(axi.rready), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_s_rdata", s_rdata, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_arlen", 32'(axi.arlen), 0);
    chk("arsize", 32'(axi.arsize), 2);
    chk("arburst", 32'(axi.arburst), 1);
    chk("arcache", 32'(axi.arcache), 2);
    chk("arprot", 32'(axi.arprot), 2);
    @(negedge clk);
    rst = 1'b0;

    run_xfer(32'h100, 16'd3, 0, 1'b0, 1'b0, -1, 0, -1);
    run_xfer(32'h000, 16'd39, 0, 1'b0, 1'b0, -1, 0, -1);
    run_xfer(32'hFF8, 16'd7, 0, 1'b0, 1'b0, -1, 0, -1);
    run_xfer(32'h300, 16'd3, 0, 1'b0, 1'b0, 2, 0, -1);
    run_xfer(32'h400, 16'd3, 0, 1'b0, 1'b0, -1, 0, -1);
    run_xfer(32'h500, 16'd3, 0, 1'b0, 1'b0, -1, 1, -1);
    run_xfer(32'h600, 16'd3, 0, 1'b0, 1'b0, -1, 2, -1);
    run_xfer(32'h700, 16'd20, 5, 1'b1, 1'b1, -1, 0, -1);
    run_xfer(32'hFFFF_FFF0, 16'd7, 1, 1'b1, 1'b0, -1, 0, -1);

    for (int t = 0; t < 12; t++) begin
      logic [31:0] ra;
      ra = $urandom & 32'hFFFF_FFFC;
      if (t % 2 == 0) ra = (ra & 32'hFFFF_F000) | 32'(4096 - 4 * $urandom_range(1, 40));
      run_xfer(ra, 16'($urandom_range(0, 70)), $urandom_range(0, 4), 1'b1, 1'b1,
               (t == 5) ? 7 : -1, 0, -1);
    end

    run_xfer(32'h2000, 16'd39, 0, 1'b0, 1'b0, -1, 0, 10);
    s_valid    = 1'b1;
    axi.rvalid = 1'b0;
    rst        = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready), 1);
    chk("midrst_arvalid", 32'(axi.arvalid), 0);
    chk("midrst_rready", 32'(axi.rready), 0);
    chk("midrst_s_ready", 32'(s_ready), 0);
    axi.arready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_xfer(32'h3000, 16'd5, 2, 1'b1, 1'b1, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
